// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register.
// Mode encoding matches the 2-bit mode input.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/usr_sat_cnt.sv
// Saturating up-counter: sync clear, increment enable,
// async active-high reset; sticks at MAX.
module usr_sat_cnt #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold / shift right / shift left / load.
// Define UNIV_SHIFT_REG_SYNC_CLR_EN to add a synchronous clr input.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROTATE = 0,
    parameter int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef UNIV_SHIFT_REG_SYNC_CLR_EN
    input  logic             clr,
`endif
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    mode_e            mode_m;
    logic             clr_w;
    logic             shr_in;
    logic             shl_in;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] qbar_d;
    logic [WIDTH-1:0] qbar_q;
    logic             do_shift;
    logic             do_load;

    assign mode_m = mode_e'(mode);

`ifdef UNIV_SHIFT_REG_SYNC_CLR_EN
    assign clr_w = clr;
`else
    assign clr_w = 1'b0;
`endif

    // Rotation feeds the outgoing bit back; otherwise the serial pin fills.
    assign shr_in = (ROTATE != 0) ? q_q[0] : sin_msb;
    assign shl_in = (ROTATE != 0) ? q_q[WIDTH-1] : sin_lsb;

    generate
        if (WIDTH == 1) begin : g_w1
            assign shr_v = shr_in;
            assign shl_v = shl_in;
        end else begin : g_wn
            assign shr_v = {shr_in, q_q[WIDTH-1:1]};
            assign shl_v = {q_q[WIDTH-2:0], shl_in};
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (clr_w) begin
            q_d = '0;
        end else if (en) begin
            unique case (mode_m)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = shr_v;
                MODE_SHL:  q_d = shl_v;
                MODE_LOAD: q_d = d;
            endcase
        end
        qbar_d = ~q_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            qbar_q <= '1;
        end else begin
            q_q    <= q_d;
            qbar_q <= qbar_d;
        end
    end

    assign do_shift = en && !clr_w &&
                      ((mode_m == MODE_SHR) || (mode_m == MODE_SHL));
    assign do_load  = clr_w || (en && (mode_m == MODE_LOAD));

    usr_sat_cnt #(
        .MAX (WIDTH),
        .W   (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (do_load),
        .inc    (do_shift),
        .cnt    (shift_cnt),
        .at_max (done)
    );

    assign q        = q_q;
    assign qbar     = qbar_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: WIDTH=8 plain, WIDTH=8 rotate, WIDTH=1.
// Reference model is integer arithmetic on the mode rules.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic       clr_r;
    logic       en;
    logic [1:0] mode;
    logic       sin_msb;
    logic       sin_lsb;
    logic [7:0] d;

    logic [7:0] q0, qb0, q1, qb1;
    logic [3:0] c0, c1;
    logic       so_l0, so_m0, dn0, so_l1, so_m1, dn1;
    logic [0:0] q2, qb2, c2;
    logic       so_l2, so_m2, dn2;

    int m0, m1, m2;
    int k0, k1, k2;
    int errors;
    int checks;

    univ_shift_reg #(.WIDTH(8), .ROTATE(0)) u0 (
        .clk(clk), .rst(rst),
`ifdef UNIV_SHIFT_REG_SYNC_CLR_EN
        .clr(clr_r),
`endif
        .en(en), .mode(mode), .sin_msb(sin_msb), .sin_lsb(sin_lsb),
        .d(d), .q(q0), .qbar(qb0), .sout_lsb(so_l0), .sout_msb(so_m0),
        .shift_cnt(c0), .done(dn0)
    );

    univ_shift_reg #(.WIDTH(8), .ROTATE(1)) u1 (
        .clk(clk), .rst(rst),
`ifdef UNIV_SHIFT_REG_SYNC_CLR_EN
        .clr(clr_r),
`endif
        .en(en), .mode(mode), .sin_msb(sin_msb), .sin_lsb(sin_lsb),
        .d(d), .q(q1), .qbar(qb1), .sout_lsb(so_l1), .sout_msb(so_m1),
        .shift_cnt(c1), .done(dn1)
    );

    univ_shift_reg #(.WIDTH(1), .ROTATE(0)) u2 (
        .clk(clk), .rst(rst),
`ifdef UNIV_SHIFT_REG_SYNC_CLR_EN
        .clr(clr_r),
`endif
        .en(en), .mode(mode), .sin_msb(sin_msb), .sin_lsb(sin_lsb),
        .d(d[0:0]), .q(q2), .qbar(qb2), .sout_lsb(so_l2), .sout_msb(so_m2),
        .shift_cnt(c2), .done(dn2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nxt_q(int w, int rot, int q);
        int mask;
        int inb;
        mask = (1 << w) - 1;
        if (clr_r) return 0;
        if (!en) return q;
        case (mode)
            2'd1: begin
                inb = rot ? (q & 1) : int'(sin_msb);
                return (q >> 1) | (inb << (w - 1));
            end
            2'd2: begin
                inb = rot ? ((q >> (w - 1)) & 1) : int'(sin_lsb);
                return ((q << 1) | inb) & mask;
            end
            2'd3: return int'(d) & mask;
            default: return q;
        endcase
    endfunction

    function automatic int nxt_c(int w, int c);
        if (clr_r) return 0;
        if (!en) return c;
        if (mode == 2'd3) return 0;
        if (mode == 2'd0) return c;
        return (c + 1 > w) ? w : c + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        m0 = nxt_q(8, 0, m0); k0 = nxt_c(8, k0);
        m1 = nxt_q(8, 1, m1); k1 = nxt_c(8, k1);
        m2 = nxt_q(1, 0, m2); k2 = nxt_c(1, k2);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] md,
                         input logic [7:0] dv);
        en   = e;
        mode = md;
        d    = dv;
    endtask

    task automatic test_reset();
        checks++;
        if (q0 !== 8'h00 || qb0 !== 8'hFF || c0 !== 4'd0 || dn0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: q=%h qbar=%h cnt=%0d done=%b want 00 FF 0 0",
                     q0, qb0, c0, dn0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'b11, 8'hA5);
        tick();
        checks++;
        if (q0 !== 8'hA5 || qb0 !== 8'h5A) begin
            errors++;
            $display("FAIL load_a5: q=%h qbar=%h want A5 5A", q0, qb0);
        end
        drive(1'b1, 2'b01, 8'h00);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q0 !== 8'h00 || qb0 !== 8'hFF || c0 !== 4'd0 || dn0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: q=%h qbar=%h cnt=%0d done=%b want 00 FF 0 0",
                     q0, qb0, c0, dn0);
        end
        rst = 1'b0;
        m0 = 0; m1 = 0; m2 = 0;
        k0 = 0; k1 = 0; k2 = 0;
    endtask

    task automatic test_serialize();
        logic seq [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        drive(1'b1, 2'b11, 8'h96);
        tick();
        drive(1'b1, 2'b01, 8'h00);
        sin_msb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (so_l0 !== seq[i]) begin
                errors++;
                $display("FAIL sout_lsb[%0d]: got %b want %b", i, so_l0, seq[i]);
            end
            tick();
            checks++;
            if (dn0 !== (i == 7)) begin
                errors++;
                $display("FAIL ser_done[%0d]: got %b want %b", i, dn0, (i == 7));
            end
        end
        checks++;
        if (q0 !== 8'h00 || c0 !== 4'd8) begin
            errors++;
            $display("FAIL ser_end: q=%h cnt=%0d want 00 8", q0, c0);
        end
    endtask

    task automatic test_rotate();
        drive(1'b1, 2'b11, 8'h81);
        tick();
        drive(1'b1, 2'b10, 8'h00);
        sin_lsb = 1'b0;
        tick();
        checks++;
        if (q1 !== 8'h03 || qb1 !== 8'hFC || c1 !== 4'd1) begin
            errors++;
            $display("FAIL rotate_shl: q=%h qbar=%h cnt=%0d want 03 FC 1",
                     q1, qb1, c1);
        end
        checks++;
        if (q0 !== 8'h02) begin
            errors++;
            $display("FAIL plain_shl: q=%h want 02", q0);
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 2'b11, 8'h0F);
        tick();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 8'h00);
            sin_msb = 1'($urandom);
            sin_lsb = 1'($urandom);
            tick();
            checks++;
            if (c0 !== 4'((i > 8) ? 8 : i) || dn0 !== (i >= 8)) begin
                errors++;
                $display("FAIL sat[%0d]: cnt=%0d done=%b want %0d %b",
                         i, c0, dn0, (i > 8) ? 8 : i, (i >= 8));
            end
        end
        drive(1'b1, 2'b11, 8'h3C);
        tick();
        checks++;
        if (c0 !== 4'd0 || dn0 !== 1'b0 || q0 !== 8'h3C) begin
            errors++;
            $display("FAIL sat_reload: cnt=%0d done=%b q=%h want 0 0 3C",
                     c0, dn0, q0);
        end
    endtask

    task automatic test_enable();
        drive(1'b1, 2'b01, 8'h00);
        tick();
        drive(1'b0, 2'b11, 8'hFF);
        tick();
        tick();
        checks++;
        if (q0 !== 8'(m0) || qb0 !== ~8'(m0) || c0 !== 4'(k0) ||
            m0 == 255) begin
            errors++;
            $display("FAIL en_hold: q=%h qbar=%h cnt=%0d want %h %h %0d",
                     q0, qb0, c0, 8'(m0), ~8'(m0), k0);
        end
    endtask

    task automatic test_width1();
        drive(1'b1, 2'b11, 8'h00);
        tick();
        drive(1'b1, 2'b01, 8'h00);
        sin_msb = 1'b1;
        tick();
        checks++;
        if (q2 !== 1'b1 || qb2 !== 1'b0 || c2 !== 1'b1 || dn2 !== 1'b1) begin
            errors++;
            $display("FAIL w1_shr: q=%b qbar=%b cnt=%0d done=%b want 1 0 1 1",
                     q2, qb2, c2, dn2);
        end
        drive(1'b1, 2'b10, 8'h00);
        sin_lsb = 1'b0;
        tick();
        checks++;
        if (q2 !== 1'b0 || c2 !== 1'b1 || so_l2 !== 1'b0 || so_m2 !== 1'b0) begin
            errors++;
            $display("FAIL w1_shl: q=%b cnt=%0d want 0 1", q2, c2);
        end
    endtask

`ifdef UNIV_SHIFT_REG_SYNC_CLR_EN
    task automatic test_clr();
        drive(1'b1, 2'b11, 8'h3C);
        tick();
        drive(1'b1, 2'b01, 8'h00);
        tick();
        drive(1'b0, 2'b11, 8'hFF);
        clr_r = 1'b1;
        tick();
        clr_r = 1'b0;
        checks++;
        if (q0 !== 8'h00 || qb0 !== 8'hFF || c0 !== 4'd0) begin
            errors++;
            $display("FAIL sync_clr: q=%h qbar=%h cnt=%0d want 00 FF 0",
                     q0, qb0, c0);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 2'($urandom), 8'($urandom));
            sin_msb = 1'($urandom);
            sin_lsb = 1'($urandom);
            tick();
            checks++;
            if (q0 !== 8'(m0) || qb0 !== ~8'(m0) || c0 !== 4'(k0) ||
                dn0 !== (k0 == 8) || so_l0 !== 1'(m0 & 1) ||
                so_m0 !== 1'((m0 >> 7) & 1)) begin
                errors++;
                $display("FAIL rnd_u0[%0d]: q=%h cnt=%0d done=%b want %h %0d",
                         i, q0, c0, dn0, 8'(m0), k0);
            end
            checks++;
            if (q1 !== 8'(m1) || qb1 !== ~8'(m1) || c1 !== 4'(k1) ||
                dn1 !== (k1 == 8)) begin
                errors++;
                $display("FAIL rnd_u1[%0d]: q=%h cnt=%0d done=%b want %h %0d",
                         i, q1, c1, dn1, 8'(m1), k1);
            end
            checks++;
            if (q2 !== 1'(m2) || qb2 !== ~1'(m2) || c2 !== 1'(k2) ||
                dn2 !== (k2 == 1)) begin
                errors++;
                $display("FAIL rnd_u2[%0d]: q=%b cnt=%0d done=%b want %0d %0d",
                         i, q2, c2, dn2, m2, k2);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        clr_r   = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        sin_msb = 1'b0;
        sin_lsb = 1'b0;
        d       = 8'h00;
        m0 = 0; m1 = 0; m2 = 0;
        k0 = 0; k1 = 0; k2 = 0;
        #2;
        test_reset();
        test_serialize();
        test_rotate();
        test_saturate();
        test_enable();
        test_width1();
`ifdef UNIV_SHIFT_REG_SYNC_CLR_EN
        test_clr();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
